gshare_branch_predictor: RTL
============================

// Module: gshare_branch_predictor
// PURPOSE
// - Direction predictor queried by branch_controller (inside hazard_controller) when DEC decodes a conditional branch.
// - Trained when EX resolves that branch.
// - Index = PC word bits XOR global history register (GHR); table of 2-bit saturating counters.
// - GHR updated speculatively at predict time; repaired on a mispredicted resolution.
// - Its prediction drives hazard_controller's dec_overload (TAKEN) and ex_overload (mismatch) logic.
// PARAMETERS
// - INDEX_WIDTH  10     log2 of counter-table entries.
// - GHR_WIDTH    10     history bits; must be <= INDEX_WIDTH (elaboration $error otherwise).
// - CNT_INIT     2'b01  counter value written by init sweep (weakly not-taken).
// PORTS
// - clk              in   1            clock
// - rst_n            in   1            asynchronous reset, active low
// - i_req_valid      in   1            DEC has a conditional branch this cycle (not asserted for jumps)
// - i_req_pc         in   32           PC of that branch
// - i_req_stall      in   1            DEC stalled (i2d_hc.stall); repeated request, no GHR update
// - o_prediction     out  1            1 = TAKEN, 0 = NOT_TAKEN; combinational from i_req_pc and GHR
// - o_req_ghr        out  GHR_WIDTH    GHR snapshot used for the prediction; carried with the branch to EX
// - i_fb_valid       in   1            EX resolved a conditional branch (ex_branch_result.valid)
// - i_fb_pc          in   32           PC of the resolved branch
// - i_fb_ghr         in   GHR_WIDTH    snapshot returned from o_req_ghr
// - i_fb_prediction  in   1            prediction made for it
// - i_fb_outcome     in   1            actual direction
// - o_ready          out  1            init sweep done
// - o_stat_pred      out  32           count of accepted predictions
// - o_stat_miss      out  32           count of mispredicted resolutions
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - GHR=0, stats=0, o_ready=0; FSM -> INIT, sweep pointer=0.
// - INIT state:
//   - Writes CNT_INIT to one entry per cycle, pointer 0..2^INDEX_WIDTH-1.
//   - After the last entry, goes to RUN and o_ready=1. Sweep takes 2^INDEX_WIDTH cycles.
//   - o_prediction forced 0; requests and feedback ignored (no GHR, counter or stat change).
// - RUN state:
//   - Predict: idx = i_req_pc[INDEX_WIDTH+1:2] ^ {zero-pad, GHR}; o_prediction = table[idx][1]; o_req_ghr = GHR.
//   - Accept when i_req_valid & ~i_req_stall: GHR <= {GHR[GHR_WIDTH-2:0], o_prediction}; o_stat_pred++.
//   - Stalled request: o_prediction and o_req_ghr stay stable, nothing updates.
//   - Train on i_fb_valid: fidx = i_fb_pc[INDEX_WIDTH+1:2] ^ i_fb_ghr.
//     - outcome=1: counter saturating +1, max 3.
//     - outcome=0: counter saturating -1, min 0.
//   - Repair when i_fb_valid and i_fb_prediction != i_fb_outcome:
//     - GHR <= {i_fb_ghr[GHR_WIDTH-2:0], i_fb_outcome}; o_stat_miss++.
// - Latency: prediction 0 cycles, combinational. Counter write is visible to reads 1 cycle later.
// - Same cycle accepted request and repair: repair wins for the GHR; the DEC branch is wrong-path and flushed.
//   - o_stat_pred still increments.
// - Same cycle read and write of the same index: the read returns the old value (no bypass).
// - Stats wrap modulo 2^32.
// - rst_n asserted mid-operation (including mid-sweep): immediate return to reset state; the sweep restarts at 0.
// STRUCTURE
// - mips_core_pkg:
//   - branch_outcome enum (NOT_TAKEN=0, TAKEN=1), already shared.
//   - typedef bp_state_t {BP_INIT, BP_RUN}.
// - One sub-module, bp_counter_table: 2^INDEX_WIDTH x 2-bit array.
//   - 1 async read port, 1 sync write port, no reset on the storage, RAM-inferable.
//   - The INIT sweep and training share its write port; the sweep has priority, and training is gated in INIT anyway.
// - Top level holds the FSM, GHR, saturating-update logic and stats counters.
// TESTING
// - Reset, then hold rst_n=1, INDEX_WIDTH=4 -> o_ready=0 for 16 cycles, 1 at cycle 16; any pc -> o_prediction=0.
// - Train pc=0x40, ghr=0, outcome=1 twice -> a request pc=0x40 with GHR=0 predicts TAKEN.
// - A 3rd and 4th outcome=1 saturate at 3; a single outcome=0 after that still predicts TAKEN.
// - Accepted request with GHR=0 and prediction 1 -> GHR=0x001.
//   - Mispredict feedback with i_fb_ghr=0x000, outcome=0 -> GHR=0x000, o_stat_miss=1.
// - Same cycle: accepted request plus mispredict feedback (i_fb_ghr=0x005, outcome=1) -> GHR=0x00B; o_stat_pred increments.
// - i_req_stall=1 for 3 cycles with i_req_valid=1 -> GHR and o_stat_pred unchanged, o_prediction stable.
// - rst_n pulsed low at sweep entry 7 -> outputs reset asynchronously; the sweep restarts and o_ready returns 16 cycles later.

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared types for the core plus the branch-predictor helpers.
//   branch_outcome : direction encoding shared by DEC/EX (NOT_TAKEN=0, TAKEN=1)
//   bp_state_t     : predictor FSM states (table init sweep, normal run)
//   sat_update     : 2-bit saturating counter step
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  // Step a 2-bit counter toward taken (up=1) or not-taken (up=0), clamped at 3/0.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table
// 2^INDEX_WIDTH x 2-bit pattern table. No reset on storage so it maps to RAM;
// contents are defined by the predictor's init sweep.
//   clk           : clock
//   pred_addr_i   : predict-side read address (async read)
//   pred_cnt_o    : counter at pred_addr_i
//   train_addr_i  : training-side read address (async read, feeds the RMW)
//   train_cnt_o   : counter at train_addr_i
//   we_i          : write enable
//   waddr_i       : write address
//   wdata_i       : write data
// Reads return the stored value; a write lands on the next clock edge, so a
// same-cycle read of the written index sees the old counter.
module bp_counter_table #(
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] pred_addr_i,
  output logic [1:0]             pred_cnt_o,
  input  logic [INDEX_WIDTH-1:0] train_addr_i,
  output logic [1:0]             train_cnt_o,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] waddr_i,
  input  logic [1:0]             wdata_i
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign pred_cnt_o  = mem[pred_addr_i];
  assign train_cnt_o = mem[train_addr_i];

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
// Gshare direction predictor for conditional branches. DEC queries it, EX
// trains it. Index = PC word bits XOR global history; 2-bit counters.
//   clk, rst_n       : clock, async active-low reset
//   i_req_valid      : DEC has a conditional branch
//   i_req_pc         : its PC
//   i_req_stall      : DEC stalled, request is a repeat (no GHR/stat update)
//   o_prediction     : 1=TAKEN, combinational from i_req_pc and GHR
//   o_req_ghr        : GHR snapshot used for this prediction (travels to EX)
//   i_fb_valid       : EX resolved a conditional branch
//   i_fb_pc          : its PC
//   i_fb_ghr         : snapshot that came back from o_req_ghr
//   i_fb_prediction  : direction that was predicted
//   i_fb_outcome     : actual direction
//   o_ready          : init sweep finished
//   o_stat_pred      : accepted predictions (wraps)
//   o_stat_miss      : mispredicted resolutions (wraps)
module gshare_branch_predictor
  import mips_core_pkg::*;
#(
  parameter int         INDEX_WIDTH = 10,
  parameter int         GHR_WIDTH   = 10,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  input  logic [31:0]          i_req_pc,
  input  logic                 i_req_stall,
  output logic                 o_prediction,
  output logic [GHR_WIDTH-1:0] o_req_ghr,
  input  logic                 i_fb_valid,
  input  logic [31:0]          i_fb_pc,
  input  logic [GHR_WIDTH-1:0] i_fb_ghr,
  input  logic                 i_fb_prediction,
  input  logic                 i_fb_outcome,
  output logic                 o_ready,
  output logic [31:0]          o_stat_pred,
  output logic [31:0]          o_stat_miss
);

  // The shift uses GHR[GHR_WIDTH-2:0], so at least two history bits are needed.
  if (GHR_WIDTH > INDEX_WIDTH || GHR_WIDTH < 2) begin : g_bad_ghr_width
    $error("gshare_branch_predictor: GHR_WIDTH must be in 2..INDEX_WIDTH");
  end

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = {INDEX_WIDTH{1'b1}};

  bp_state_t              state_q;
  logic [INDEX_WIDTH-1:0] ptr_q;
  logic                   ready_q;
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [31:0]            stat_pred_q, stat_pred_d;
  logic [31:0]            stat_miss_q, stat_miss_d;

  logic                   run;
  logic [INDEX_WIDTH-1:0] req_idx, fb_idx;
  logic [1:0]             req_cnt, fb_cnt;
  logic                   accept, train, miss;
  logic                   tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_waddr;
  logic [1:0]             tbl_wdata;

  assign run = (state_q == BP_RUN);

  // History is zero-extended to the index width before hashing.
  assign req_idx = i_req_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign fb_idx  = i_fb_pc[INDEX_WIDTH+1:2]  ^ INDEX_WIDTH'(i_fb_ghr);

  bp_counter_table #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_table (
    .clk          (clk),
    .pred_addr_i  (req_idx),
    .pred_cnt_o   (req_cnt),
    .train_addr_i (fb_idx),
    .train_cnt_o  (fb_cnt),
    .we_i         (tbl_we),
    .waddr_i      (tbl_waddr),
    .wdata_i      (tbl_wdata)
  );

  assign o_prediction = run & req_cnt[1];
  assign o_req_ghr    = ghr_q;
  assign o_ready      = ready_q;
  assign o_stat_pred  = stat_pred_q;
  assign o_stat_miss  = stat_miss_q;

  assign accept = run & i_req_valid & ~i_req_stall;
  assign train  = run & i_fb_valid;
  assign miss   = train & (i_fb_prediction != i_fb_outcome);

  // Sweep owns the write port while initialising; training only runs after.
  always_comb begin
    tbl_we    = train;
    tbl_waddr = fb_idx;
    tbl_wdata = sat_update(fb_cnt, i_fb_outcome);
    if (!run) begin
      tbl_we    = 1'b1;
      tbl_waddr = ptr_q;
      tbl_wdata = CNT_INIT;
    end
  end

  // A repair means the branch now in DEC is wrong-path, so its speculative
  // history push is dropped; its prediction still counts as accepted.
  always_comb begin
    ghr_d       = ghr_q;
    stat_pred_d = stat_pred_q;
    stat_miss_d = stat_miss_q;
    if (accept) begin
      ghr_d       = {ghr_q[GHR_WIDTH-2:0], o_prediction};
      stat_pred_d = stat_pred_q + 32'd1;
    end
    if (miss) begin
      ghr_d       = {i_fb_ghr[GHR_WIDTH-2:0], i_fb_outcome};
      stat_miss_d = stat_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        BP_INIT: begin
          if (ptr_q == LAST_IDX) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        BP_RUN: begin
          state_q <= BP_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= BP_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q       <= '0;
      stat_pred_q <= '0;
      stat_miss_q <= '0;
    end else begin
      ghr_q       <= ghr_d;
      stat_pred_q <= stat_pred_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  // PC bits outside the index field are intentionally not hashed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_req_pc[31:INDEX_WIDTH+2], i_req_pc[1:0],
                            i_fb_pc[31:INDEX_WIDTH+2], i_fb_pc[1:0]};

endmodule
